// File: rtl/btn_led_ctrl_pkg.sv
// Shared types and constants for the button/LED controller.
// Optional input synchronizer is enabled with BTN_LED_CTRL_SYNC_EN.
package btn_led_ctrl_pkg;

    localparam int LED_W = 5;
    localparam int BTN_N = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        XOR   = 2'd1,
        COUNT = 2'd2,
        BLINK = 2'd3
    } mode_e;

endpackage

// File: rtl/btn_led_ctrl_debounce.sv
// One-button synchronizer, debouncer and press-pulse generator.
// Define BTN_LED_CTRL_SYNC_EN to insert a two-flop synchronizer.
module debounce #(
    parameter int DEBOUNCE_CYCLES_P = 120000
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic button_async_unsafe_i,
    output logic level_o,
    output logic press_o
);

    localparam int CW = (DEBOUNCE_CYCLES_P > 1) ? $clog2(DEBOUNCE_CYCLES_P) : 1;
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES_P - 1);

    logic          sync;
    logic          level;
    logic [CW-1:0] cnt;
    logic          accept;

`ifdef BTN_LED_CTRL_SYNC_EN
    logic meta;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            meta <= 1'b0;
            sync <= 1'b0;
        end else begin
            meta <= button_async_unsafe_i;
            sync <= meta;
        end
    end
`else
    assign sync = button_async_unsafe_i;
`endif

    // The pulse fires on the same edge the new level is accepted.
    assign accept = (sync != level) && (cnt == LAST);

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            cnt   <= '0;
            level <= 1'b0;
        end else if (sync == level) begin
            cnt <= '0;
        end else if (accept) begin
            cnt   <= '0;
            level <= sync;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign level_o = level;
    assign press_o = accept & sync;

endmodule

// File: rtl/btn_led_ctrl.sv
// Three-button mode controller driving five LEDs (IDLE/XOR/COUNT/BLINK).
// Define BTN_LED_CTRL_SYNC_EN to synchronize the raw button inputs.
module btn_led_ctrl
    import btn_led_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES_P = 120000,
    parameter int BLINK_CYCLES_P    = 6000000
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic [2:0]       button_async_unsafe_i,
    output logic [LED_W-1:0] led_o,
    output logic [1:0]       mode_o
);

    localparam int BW = (BLINK_CYCLES_P > 1) ? $clog2(BLINK_CYCLES_P) : 1;
    localparam logic [BW-1:0] BLAST = BW'(BLINK_CYCLES_P - 1);

    logic [BTN_N-1:0] level;
    logic [BTN_N-1:0] press;
    logic             unused_level;

    mode_e         state;
    mode_e         state_next;
    logic [3:0]    count;
    logic [BW-1:0] blink_cnt;
    logic          blink_pat;

    for (genvar i = 0; i < BTN_N; i++) begin : g_btn
        debounce #(
            .DEBOUNCE_CYCLES_P(DEBOUNCE_CYCLES_P)
        ) u_debounce (
            .clk_i                (clk_i),
            .reset_i              (reset_i),
            .button_async_unsafe_i(button_async_unsafe_i[i]),
            .level_o              (level[i]),
            .press_o              (press[i])
        );
    end

    assign unused_level = level[2];

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (press[2]) begin
            unique case (state)
                IDLE:  state_next = XOR;
                XOR:   state_next = COUNT;
                COUNT: state_next = BLINK;
                BLINK: state_next = IDLE;
            endcase
        end
    end

    // A mode press on the same cycle masks any count press.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            count <= 4'h0;
        end else if (state_next == COUNT && state != COUNT) begin
            count <= 4'h0;
        end else if (state == COUNT && !press[2]) begin
            unique case ({press[0], press[1]})
                2'b10:   count <= count + 4'h1;
                2'b01:   count <= count - 4'h1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            blink_cnt <= '0;
            blink_pat <= 1'b0;
        end else if (state_next == BLINK && state != BLINK) begin
            blink_cnt <= '0;
            blink_pat <= 1'b0;
        end else if (state == BLINK) begin
            if (blink_cnt == BLAST) begin
                blink_cnt <= '0;
                blink_pat <= ~blink_pat;
            end else begin
                blink_cnt <= blink_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        led_o = '0;
        unique case (state)
            IDLE:  led_o = '0;
            XOR:   led_o = {1'b1, 3'b000, level[0] ^ level[1]};
            COUNT: led_o = {1'b1, count};
            BLINK: led_o = {1'b1, {4{blink_pat}}};
        endcase
    end

    assign mode_o = state;

endmodule

// File: tb/tb_btn_led_ctrl.sv
// Self-checking bench for btn_led_ctrl with a window-based reference model.
// Latency expectations follow BTN_LED_CTRL_SYNC_EN when it is defined.
module tb_btn_led_ctrl;

    localparam int DEB = 4;
    localparam int BLK = 8;
`ifdef BTN_LED_CTRL_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif
    localparam int HOLD = LAT + DEB + 1;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [2:0] btn = 3'b000;
    logic [4:0] led;
    logic [1:0] mode;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    btn_led_ctrl #(
        .DEBOUNCE_CYCLES_P(DEB),
        .BLINK_CYCLES_P   (BLK)
    ) dut (
        .clk_i                (clk),
        .reset_i              (reset),
        .button_async_unsafe_i(btn),
        .led_o                (led),
        .mode_o               (mode)
    );

    // Reference model: a level flips once the last DEB delayed samples all
    // disagree with it; blink phase is derived from time since entry.
    logic [2:0] hist[$];
    logic [2:0] dq[$];
    logic [2:0] m_lvl = 3'b000;
    int m_mode = 0;
    int m_cnt = 0;
    int m_blink_start = 0;
    int edge_n = 0;

    task automatic model_step(input logic [2:0] b, input logic r);
        logic [2:0] d;
        logic [2:0] p;
        bit all_diff;
        edge_n++;
        p = 3'b000;
        if (r) begin
            hist.delete();
            dq.delete();
            hist.push_back(3'b000);
            m_lvl = 3'b000;
            m_mode = 0;
            m_cnt = 0;
            return;
        end
        hist.push_back(b);
        d = (hist.size() > LAT) ? hist[hist.size() - 1 - LAT] : 3'b000;
        dq.push_back(d);
        for (int i = 0; i < 3; i++) begin
            if (dq.size() >= DEB) begin
                all_diff = 1'b1;
                for (int k = 0; k < DEB; k++)
                    if (dq[dq.size() - 1 - k][i] == m_lvl[i]) all_diff = 1'b0;
                if (all_diff) begin
                    m_lvl[i] = ~m_lvl[i];
                    if (m_lvl[i]) p[i] = 1'b1;
                end
            end
        end
        while (hist.size() > 8) void'(hist.pop_front());
        while (dq.size() > 8) void'(dq.pop_front());
        if (p[2]) begin
            m_mode = (m_mode + 1) % 4;
            if (m_mode == 2) m_cnt = 0;
            if (m_mode == 3) m_blink_start = edge_n;
        end else if (m_mode == 2) begin
            m_cnt = (m_cnt + int'(p[0]) - int'(p[1])) & 15;
        end
    endtask

    function automatic logic [4:0] exp_led();
        case (m_mode)
            1: return {1'b1, 3'b000, m_lvl[0] ^ m_lvl[1]};
            2: return {1'b1, 4'(m_cnt)};
            3: return (((edge_n - m_blink_start) / BLK) % 2) ? 5'h1F : 5'h10;
            default: return 5'h00;
        endcase
    endfunction

    task automatic tick(input logic [2:0] b, input logic r);
        btn = b;
        reset = r;
        @(posedge clk);
        model_step(b, r);
        @(negedge clk);
    endtask

    task automatic press(input logic [2:0] m);
        repeat (HOLD) tick(m, 1'b0);
        repeat (HOLD) tick(3'b000, 1'b0);
    endtask

    task automatic test_reset();
        repeat (2) tick(3'b000, 1'b1);
        for (int i = 0; i < 6; i++) begin
            if (i > 0) tick(3'b000, 1'b0);
            checks++;
            if (led !== 5'b00000 || mode !== 2'd0) begin
                errors++;
                $display("FAIL reset_idle: led=%b mode=%0d want led=00000 mode=0", led, mode);
            end
        end
    endtask

    task automatic test_glitch();
        repeat (3) tick(3'b100, 1'b0);
        repeat (6) tick(3'b000, 1'b0);
        checks++;
        if (mode !== 2'd0) begin
            errors++;
            $display("FAIL glitch: mode=%0d want 0", mode);
        end
        for (int i = 1; i <= 6; i++) begin
            tick(3'b100, 1'b0);
            checks++;
            if (mode !== ((i >= LAT + DEB) ? 2'd1 : 2'd0)) begin
                errors++;
                $display("FAIL held_rise[%0d]: mode=%0d want %0d", i, mode,
                         (i >= LAT + DEB) ? 1 : 0);
            end
        end
        repeat (HOLD) tick(3'b000, 1'b0);
        checks++;
        if (mode !== 2'd1 || mode !== 2'(m_mode)) begin
            errors++;
            $display("FAIL release_no_pulse: mode=%0d want 1", mode);
        end
    endtask

    task automatic test_xor();
        repeat (HOLD) tick(3'b001, 1'b0);
        checks++;
        if (led !== 5'b10001 || led !== exp_led()) begin
            errors++;
            $display("FAIL xor_10: led=%b want 10001", led);
        end
        repeat (HOLD) tick(3'b011, 1'b0);
        checks++;
        if (led !== 5'b10000 || led !== exp_led()) begin
            errors++;
            $display("FAIL xor_11: led=%b want 10000", led);
        end
        repeat (HOLD) tick(3'b000, 1'b0);
    endtask

    task automatic test_count();
        press(3'b100);
        checks++;
        if (mode !== 2'd2 || led !== 5'b10000) begin
            errors++;
            $display("FAIL count_entry: led=%b mode=%0d want led=10000 mode=2", led, mode);
        end
        press(3'b010);
        checks++;
        if (led !== 5'b11111) begin
            errors++;
            $display("FAIL count_wrap_down: led=%b want 11111", led);
        end
        for (int i = 0; i < 17; i++) begin
            press(3'b001);
            checks++;
            if (led !== exp_led()) begin
                errors++;
                $display("FAIL count_inc[%0d]: led=%b want %b", i, led, exp_led());
            end
        end
        checks++;
        if (led !== 5'b10000) begin
            errors++;
            $display("FAIL count_wrap_up: led=%b want 10000", led);
        end
        press(3'b001);
        press(3'b011);
        checks++;
        if (led !== 5'b10001) begin
            errors++;
            $display("FAIL count_both: led=%b want 10001", led);
        end
        press(3'b101);
        checks++;
        if (mode !== 2'd3 || mode !== 2'(m_mode)) begin
            errors++;
            $display("FAIL mode_beats_count: mode=%0d want 3", mode);
        end
    endtask

    task automatic test_blink();
        logic [3:0] prev;
        int last_change;
        prev = led[3:0];
        last_change = -1;
        for (int i = 0; i < 40; i++) begin
            tick(3'b000, 1'b0);
            checks++;
            if (led !== exp_led() || led[4] !== 1'b1 ||
                (led[3:0] !== 4'h0 && led[3:0] !== 4'hF)) begin
                errors++;
                $display("FAIL blink[%0d]: led=%b want %b", i, led, exp_led());
            end
            if (led[3:0] !== prev) begin
                if (last_change >= 0) begin
                    checks++;
                    if (edge_n - last_change != BLK) begin
                        errors++;
                        $display("FAIL blink_period: got %0d want %0d",
                                 edge_n - last_change, BLK);
                    end
                end
                last_change = edge_n;
                prev = led[3:0];
            end
        end
        press(3'b100);
        checks++;
        if (mode !== 2'd0 || led !== 5'b00000) begin
            errors++;
            $display("FAIL blink_exit: led=%b mode=%0d want led=00000 mode=0", led, mode);
        end
    endtask

    task automatic test_reset_mid();
        press(3'b100);
        press(3'b100);
        repeat (5) press(3'b001);
        checks++;
        if (led !== 5'b10101 || mode !== 2'd2) begin
            errors++;
            $display("FAIL pre_reset: led=%b mode=%0d want led=10101 mode=2", led, mode);
        end
        tick(3'b000, 1'b1);
        checks++;
        if (led !== 5'b00000 || mode !== 2'd0) begin
            errors++;
            $display("FAIL reset_mid: led=%b mode=%0d want led=00000 mode=0", led, mode);
        end
        for (int i = 0; i < 2 * HOLD; i++) begin
            tick(3'b000, 1'b0);
            checks++;
            if (mode !== 2'd0) begin
                errors++;
                $display("FAIL post_reset[%0d]: mode=%0d want 0", i, mode);
            end
        end
        repeat (HOLD - 2) tick(3'b100, 1'b0);
        tick(3'b100, 1'b1);
        repeat (HOLD - 2) tick(3'b100, 1'b0);
        repeat (HOLD) tick(3'b000, 1'b0);
        checks++;
        if (mode !== 2'd0 || mode !== 2'(m_mode)) begin
            errors++;
            $display("FAIL reset_debounce: mode=%0d want 0", mode);
        end
    endtask

    task automatic test_random();
        logic [2:0] b;
        logic r;
        int left;
        b = 3'b000;
        left = 0;
        for (int i = 0; i < 1500; i++) begin
            if (left == 0) begin
                b = 3'($urandom_range(0, 7));
                left = $urandom_range(1, 9);
            end
            left--;
            r = ($urandom_range(0, 299) == 0);
            tick(b, r);
            checks++;
            if (led !== exp_led() || mode !== 2'(m_mode)) begin
                errors++;
                $display("FAIL random[%0d]: led=%b mode=%0d want led=%b mode=%0d",
                         i, led, mode, exp_led(), m_mode);
            end
        end
    endtask

    initial begin
        test_reset();
        test_glitch();
        test_xor();
        test_count();
        test_blink();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
